// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter sharing one data memory port between two requesters
module dmem_arbiter #(
  parameter int MAX_HOLD = 4,
  parameter bit PRIO0    = 1'b1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        m0_req,
  input  logic [31:0] m0_addr,
  input  logic [3:0]  m0_wmask,
  input  logic [31:0] m0_wdata,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic [31:0] m1_addr,
  input  logic [3:0]  m1_wmask,
  input  logic [31:0] m1_wdata,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wmask,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_data
);
  localparam logic [3:0] MAX_HOLD_C = 4'(MAX_HOLD);
  logic       last_q, last_d;
  logic [3:0] hold_q, hold_d;
  logic       rsel_q, rsel_d;
  logic       rpend_q, rpend_d;
  logic       both, active, win;
  // Pick the winner (1 = m1) and steer its payload onto the memory port; reset blocks any grant
  always_comb begin
    both      = m0_req && m1_req;
    active    = resetn && (m0_req || m1_req);
    win       = both ? ((hold_q < MAX_HOLD_C) ? last_q : ~last_q) : m1_req;
    m0_gnt    = active && !win;
    m1_gnt    = active && win;
    mem_addr  = win ? m1_addr : m0_addr;
    mem_wdata = win ? m1_wdata : m0_wdata;
    mem_wmask = active ? (win ? m1_wmask : m0_wmask) : 4'h0;
  end
  // Streak counter restarts on a new owner, saturates at the hold limit and clears on idle cycles
  always_comb begin
    last_d  = active ? win : last_q;
    hold_d  = !active ? 4'h0 : (win != last_q) ? 4'h1 : (hold_q < MAX_HOLD_C) ? hold_q + 4'h1 : MAX_HOLD_C;
    rpend_d = active && (mem_wmask == 4'h0);
    rsel_d  = rpend_d ? win : rsel_q;
  end
  // State registers; last starts at ~PRIO0 so the first tie goes to PRIO0's requester
  always_ff @(posedge clk) begin
    if (!resetn) begin
      last_q  <= ~PRIO0;
      hold_q  <= 4'h0;
      rsel_q  <= 1'b0;
      rpend_q <= 1'b0;
    end else begin
      last_q  <= last_d;
      hold_q  <= hold_d;
      rsel_q  <= rsel_d;
      rpend_q <= rpend_d;
    end
  end
  assign m0_rvalid = resetn && rpend_q && !rsel_q;
  assign m1_rvalid = resetn && rpend_q && rsel_q;
  assign m0_rdata  = mem_data;
  assign m1_rdata  = mem_data;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: two arbiter configurations against a behavioural model with a shared stimulus
module tb_dmem_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic resetn;
  logic m0_req, m1_req;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
  logic [3:0] m0_wmask, m1_wmask;
  logic [1:0] g0, g1, rv0, rv1;
  logic [1:0][31:0] rd0, rd1, maddr, mwdata, mdata;
  logic [1:0][3:0] mwmask;
  logic [31:0] emem [2][16];
  int n_cmp = 0, n_bad = 0;
  int mh [2] = '{4, 1};
  bit prio [2] = '{1'b1, 1'b0};
  bit own [2];
  int streak [2];
  bit pend [2], psel [2];
  logic [31:0] pdata [2];
  logic [31:0] refmem [2][16];

  dmem_arbiter #(.MAX_HOLD(4), .PRIO0(1'b1)) u_a (
    .clk(clk), .resetn(resetn),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_wmask(m0_wmask), .m0_wdata(m0_wdata),
    .m0_gnt(g0[0]), .m0_rvalid(rv0[0]), .m0_rdata(rd0[0]),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_wmask(m1_wmask), .m1_wdata(m1_wdata),
    .m1_gnt(g1[0]), .m1_rvalid(rv1[0]), .m1_rdata(rd1[0]),
    .mem_addr(maddr[0]), .mem_wmask(mwmask[0]), .mem_wdata(mwdata[0]), .mem_data(mdata[0])
  );
  dmem_arbiter #(.MAX_HOLD(1), .PRIO0(1'b0)) u_b (
    .clk(clk), .resetn(resetn),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_wmask(m0_wmask), .m0_wdata(m0_wdata),
    .m0_gnt(g0[1]), .m0_rvalid(rv0[1]), .m0_rdata(rd0[1]),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_wmask(m1_wmask), .m1_wdata(m1_wdata),
    .m1_gnt(g1[1]), .m1_rvalid(rv1[1]), .m1_rdata(rd1[1]),
    .mem_addr(maddr[1]), .mem_wmask(mwmask[1]), .mem_wdata(mwdata[1]), .mem_data(mdata[1])
  );

  // Data memories behind each arbiter: read-before-write, data one cycle after the address
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      mdata[i] <= emem[i][maddr[i][5:2]];
      for (int b = 0; b < 4; b++)
        if (mwmask[i][b]) emem[i][maddr[i][5:2]][8*b +: 8] <= mwdata[i][8*b +: 8];
    end
  end

  function automatic logic act();
    return resetn && (m0_req || m1_req);
  endfunction

  function automatic logic win(int i);
    if (m0_req && m1_req) return (streak[i] < mh[i]) ? own[i] : !own[i];
    return m1_req;
  endfunction

  task automatic chk(input string nm, input int i, input logic [31:0] a, input logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s[%0d] at %0t: got %h want %h", nm, i, $time, a, e);
    end
  endtask

  task automatic settle();
    logic w, a;
    #2;
    for (int i = 0; i < 2; i++) begin
      w = win(i);
      a = act();
      chk("gnt0", i, 32'(g0[i]), 32'(a && !w));
      chk("gnt1", i, 32'(g1[i]), 32'(a && w));
      chk("wmask", i, 32'(mwmask[i]), 32'(a ? (w ? m1_wmask : m0_wmask) : 4'h0));
      if (resetn) begin
        chk("addr", i, maddr[i], w ? m1_addr : m0_addr);
        chk("wdata", i, mwdata[i], w ? m1_wdata : m0_wdata);
      end
      chk("rvalid0", i, 32'(rv0[i]), 32'(resetn && pend[i] && !psel[i]));
      chk("rvalid1", i, 32'(rv1[i]), 32'(resetn && pend[i] && psel[i]));
      if (resetn && pend[i]) chk("rdata", i, psel[i] ? rd1[i] : rd0[i], pdata[i]);
    end
  endtask

  task automatic update(input int i);
    logic w;
    logic [31:0] a, d;
    logic [3:0] m;
    if (!resetn) begin
      own[i] = !prio[i];
      streak[i] = 0;
      pend[i] = 1'b0;
      psel[i] = 1'b0;
    end else if (act()) begin
      w = win(i);
      a = w ? m1_addr : m0_addr;
      d = w ? m1_wdata : m0_wdata;
      m = w ? m1_wmask : m0_wmask;
      streak[i] = (w == own[i]) ? ((streak[i] < mh[i]) ? streak[i] + 1 : mh[i]) : 1;
      own[i] = w;
      pend[i] = (m == 4'h0);
      psel[i] = w;
      if (pend[i]) pdata[i] = refmem[i][a[5:2]];
      for (int b = 0; b < 4; b++)
        if (m[b]) refmem[i][a[5:2]][8*b +: 8] = d[8*b +: 8];
    end else begin
      streak[i] = 0;
      pend[i] = 1'b0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    update(0);
    update(1);
    @(negedge clk);
  endtask

  task automatic cyc();
    settle();
    tick();
  endtask

  task automatic drive(input logic r0, input logic [31:0] a0, input logic [3:0] k0, input logic [31:0] d0,
                       input logic r1, input logic [31:0] a1, input logic [3:0] k1, input logic [31:0] d1);
    m0_req = r0; m0_addr = a0; m0_wmask = k0; m0_wdata = d0;
    m1_req = r1; m1_addr = a1; m1_wmask = k1; m1_wdata = d1;
  endtask

  initial begin
    resetn = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++)
      for (int w = 0; w < 16; w++) begin
        emem[i][w] = 32'h1000_0000 + 32'(w) * 32'h0101_0101;
        refmem[i][w] = emem[i][w];
      end
    emem[0][4] = 32'hDEAD_BEEF; emem[1][4] = 32'hDEAD_BEEF;
    refmem[0][4] = 32'hDEAD_BEEF; refmem[1][4] = 32'hDEAD_BEEF;
    @(negedge clk);
    // reset with both requesting writes: no grant, no write
    drive(1, 32'h10, 4'hF, 32'h55, 1, 32'h20, 4'hF, 32'h66);
    for (int k = 0; k < 3; k++) begin
      settle();
      for (int i = 0; i < 2; i++) begin
        chk("rst_gnt", i, 32'({g0[i], g1[i]}), 32'h0);
        chk("rst_wmask", i, 32'(mwmask[i]), 32'h0);
      end
      tick();
    end
    // first tie and fairness: A gives m0 x4 then m1 x4; B alternates starting with m1
    resetn = 1'b1;
    drive(1, 32'h10, 0, 0, 1, 32'h20, 0, 0);
    for (int k = 1; k <= 9; k++) begin
      settle();
      chk("tie_a1", 0, 32'(g1[0]), 32'(k >= 5 && k <= 8));
      chk("tie_a0", 0, 32'(g0[0]), 32'(!(k >= 5 && k <= 8)));
      chk("alt_b1", 1, 32'(g1[1]), 32'(k % 2 == 1));
      chk("alt_rv_b", 1, 32'(rv1[1]), 32'(k >= 2 && k % 2 == 0));
      tick();
    end
    // single requester read
    drive(0, 0, 0, 0, 1, 32'h10, 0, 0);
    settle();
    for (int i = 0; i < 2; i++) chk("single_gnt", i, 32'(g1[i]), 32'h1);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    settle();
    for (int i = 0; i < 2; i++) begin
      chk("single_rv1", i, 32'(rv1[i]), 32'h1);
      chk("single_rv0", i, 32'(rv0[i]), 32'h0);
      chk("single_rd", i, rd1[i], 32'hDEAD_BEEF);
    end
    tick();
    // write then read across requesters, then byte write and reread
    drive(1, 32'h20, 4'hF, 32'h1122_3344, 0, 0, 0, 0);
    cyc();
    drive(0, 0, 0, 0, 1, 32'h20, 0, 0);
    cyc();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    settle();
    for (int i = 0; i < 2; i++) chk("wr_rd", i, rd1[i], 32'h1122_3344);
    tick();
    drive(1, 32'h20, 4'h2, 32'h0000_AA00, 0, 0, 0, 0);
    cyc();
    drive(0, 0, 0, 0, 1, 32'h20, 0, 0);
    cyc();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    settle();
    for (int i = 0; i < 2; i++) chk("byte_rd", i, rd1[i], 32'h1122_AA44);
    tick();
    // idle cycle clears the streak: m0 x3, idle, then both -> m0 x4 before m1
    drive(1, 32'h04, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) cyc();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    cyc();
    drive(1, 32'h04, 0, 0, 1, 32'h08, 0, 0);
    for (int k = 1; k <= 5; k++) begin
      settle();
      chk("idle_a", 0, 32'(g1[0]), 32'(k == 5));
      tick();
    end
    // reset while a read is in flight
    drive(1, 32'h30, 0, 0, 0, 0, 0, 0);
    cyc();
    resetn = 1'b0;
    drive(1, 32'h30, 4'hF, 32'hBAD0_BAD0, 1, 32'h34, 4'hF, 32'hBAD1_BAD1);
    for (int k = 0; k < 2; k++) begin
      settle();
      for (int i = 0; i < 2; i++) begin
        chk("midrst_rv0", i, 32'(rv0[i]), 32'h0);
        chk("midrst_wmask", i, 32'(mwmask[i]), 32'h0);
      end
      tick();
    end
    resetn = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    settle();
    for (int i = 0; i < 2; i++) chk("postrst_rv", i, 32'({rv0[i], rv1[i]}), 32'h0);
    tick();
    // randomized traffic with occasional resets
    for (int n = 0; n < 3000; n++) begin
      resetn = ($urandom_range(0, 199) != 0);
      drive($urandom_range(0, 3) != 0, 32'($urandom_range(0, 15)) << 2,
            $urandom_range(0, 1) ? 4'h0 : 4'($urandom_range(1, 15)), $urandom,
            $urandom_range(0, 3) != 0, 32'($urandom_range(0, 15)) << 2,
            $urandom_range(0, 1) ? 4'h0 : 4'($urandom_range(1, 15)), $urandom);
      cyc();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Round-robin arbiter that shares one port of the dual-port data memory between two requesters, for example a hart's load/store unit and a debug/loader engine. It sits directly in front of one `a_mem_*` or `b_mem_*` port set of `data_mem`. It grants at most one access per cycle and bounds how long a single requester can monopolise the port. It tags the one-cycle-later read data back to the requester that issued the access.

## Interface
Parameters:
- `MAX_HOLD`, default 4: maximum consecutive grants to one requester while the other is requesting; range 1..15.
- `PRIO0`, default 1: requester favoured on the first cycle after reset (1 means m0, 0 means m1).

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `resetn` input 1: synchronous, active-low reset.
- `m0_req` input 1: requester 0 access request; the payload must be held stable until granted.
- `m0_addr` input 32: byte address; bits [1:0] are ignored downstream.
- `m0_wmask` input 4: byte write enables; 0 means a read.
- `m0_wdata` input 32: write data.
- `m0_gnt` output 1: combinational grant; the access is issued this cycle.
- `m0_rvalid` output 1: registered; `m0_rdata` is valid this cycle.
- `m0_rdata` output 32: read data, a pass-through of `mem_data`.
- `m1_req`, `m1_addr`, `m1_wmask`, `m1_wdata`, `m1_gnt`, `m1_rvalid`, `m1_rdata`: same as the m0 ports, for requester 1.
- `mem_addr` output 32: to the data memory port.
- `mem_wmask` output 4: to the data memory port; forced to 0 when nothing is granted.
- `mem_wdata` output 32: to the data memory port.
- `mem_data` input 32: from the data memory port; carries the word for the address presented on the previous cycle.

## Operation
- State: `last` (1 bit, the requester granted most recently), `hold_cnt` (4 bits, consecutive grants to `last`), `rsel` (1 bit, owner of the in-flight read), `rpend` (1 bit, a read is in flight).
- Grant rules, combinational in each cycle:
  - Only one requester active: that requester is granted.
  - Both active and `hold_cnt < MAX_HOLD`: `last` is granted again.
  - Both active and `hold_cnt == MAX_HOLD`: `~last` is granted.
  - Neither active: no grant; `mem_wmask` = 0; `mem_addr` and `mem_wdata` still drive the m0 payload.
- Write muxing: the winner's addr, wmask and wdata are driven onto `mem_*` in the same cycle as `gnt`.
- Register update on a granted cycle:
  - Winner equal to `last`: `hold_cnt` ← `hold_cnt + 1`, saturating at `MAX_HOLD`.
  - Winner different from `last`: `last` ← winner and `hold_cnt` ← 1.
- Register update on a cycle with no grant: `hold_cnt` ← 0 and `last` is unchanged.
- Read tracking: a granted access with `wmask == 0` sets `rpend` ← 1 and `rsel` ← winner. Any other cycle clears `rpend`.
- Read response: `mX_rvalid` = `rpend && rsel == X`.
- Writes: no response. `gnt` completes the write; the memory commits it at the clock edge that ends the grant cycle.
- Read data: `m0_rdata` and `m1_rdata` both carry `mem_data` unconditionally. Each requester qualifies it with its own rvalid.
- Back-to-back: a new grant may be issued in the same cycle as the previous read's rvalid, so throughput is one access per cycle.
- Same-address write then read: ordering follows grant order. The memory is read-before-write within a cycle, so a read issued in the same cycle as a write returns the old word. Different requesters cannot be granted in the same cycle, so this case does not arise here.

## Timing
- Reset, while `resetn` is sampled low: `rpend` = 0, `rsel` = 0, `hold_cnt` = 0, `last` = ~`PRIO0`.
  - The `last` value gives the first tie after reset to requester `PRIO0`.
  - While `resetn` is low, `gnt` is forced to 0 and `mem_wmask` to 0, so no write can occur during reset.
  - rvalid outputs are 0 on the first cycle after reset.
- Reset mid-read: an outstanding rvalid is dropped, and no response is delivered after reset.
- Grant latency: 0 cycles from `req`, combinational.
- Read data latency: rvalid is asserted exactly 1 cycle after the gnt cycle.
- Requester contract:
  - Hold `req` and the payload until the cycle in which `gnt` is high.
  - Deasserting `req` or changing the payload on the cycle after `gnt` starts a new request.
  - Dropping `req` before grant is legal; the request is simply withdrawn.
- Starvation bound: with both requesters continuously requesting, each waits at most `MAX_HOLD` cycles between grants.

## Test plan
- Reset and first tie, default parameters: hold `resetn` low for 3 cycles with both requesting → both gnt stay 0 and `mem_wmask` = 0. Release reset → first grant goes to m0, and `m0_gnt` is high for 4 consecutive cycles. Cycle 5 → `m1_gnt`. Cycles 5-8 → m1 is granted 4 times. Cycle 9 → m0 again.
- Single-requester read: m1 reads addr 0x10 with the memory word at 0x10 preset to 0xDEADBEEF → `m1_gnt` is high the same cycle, and on the next cycle `m1_rvalid` = 1 with `m1_rdata` = 0xDEADBEEF. `m0_rvalid` stays 0 throughout.
- Write then read across requesters:
  - m0 writes 0x11223344 to 0x20 with wmask 0xF.
  - Next cycle, m1 reads 0x20 → `m1_rdata` = 0x11223344 one cycle after its grant.
  - m0 then does a byte write of 0xAA to 0x20 with wmask 0x2, and m1 rereads 0x20 → 0x1122AA44.
- Alternating requests, `MAX_HOLD` = 1: both requesters continuously request reads → grants alternate m0, m1, m0, …, and each rvalid lands on the correct requester one cycle after its grant.
- Idle reset of hold count: m0 is granted 3 times, one idle cycle follows, then both request → m0 is granted 4 more times before m1, because the idle cycle cleared `hold_cnt`.
- Reset mid-read: m0 is granted a read and `resetn` drops on the next cycle → `m0_rvalid` stays 0, and no stray write occurs (`mem_wmask` = 0 throughout reset).
